mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 32, meaning the number of 32-bit words in the shared single-port RAM.
REQ-002 The block SHALL have parameter STARVE_MAX, default 3, meaning the number of consecutive denied instruction-request cycles before the instruction port wins arbitration.
REQ-003 The ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_req  in  1  instruction fetch request.
- i_addr  in  32  fetch byte address.
- i_gnt  out  1  fetch request accepted this cycle.
- i_rvalid  out  1  fetch response valid.
- i_rdata  out  32  fetch data.
- i_err  out  1  fetch error, qualified by i_rvalid.
- d_req  in  1  data request.
- d_we  in  1  data write enable.
- d_be  in  4  data byte enables.
- d_addr  in  32  data byte address.
- d_wdata  in  32  write data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  data response valid.
- d_rdata  out  32  load data.
- d_err  out  1  data error, qualified by d_rvalid.
- m_en  out  1  RAM access enable.
- m_we  out  1  RAM write enable.
- m_be  out  4  RAM byte enables.
- m_addr  out  $clog2(MEM_WORDS)  RAM word index.
- m_wdata  out  32  RAM write data.
- m_rdata  in  32  RAM read data, valid one cycle after m_en with m_we low.

Function
REQ-004 Grants, m_* outputs and the error check SHALL be combinational from the current requests and registered state; responses SHALL be registered.
REQ-005 At most one port SHALL be granted per cycle; a port with req low SHALL never be granted.
REQ-006 When both ports request, data SHALL win unless starve_cnt == STARVE_MAX, in which case instruction SHALL win.
REQ-007 starve_cnt SHALL increment, saturating at STARVE_MAX, on each cycle i_req is high and i_gnt is low, and SHALL clear on any cycle i_gnt is high or i_req is low.
REQ-008 A request SHALL be an error if addr[1:0] != 0 or addr[31:2] >= MEM_WORDS.
REQ-009 A granted request SHALL drive m_en=1, m_addr=addr[2+:$clog2(MEM_WORDS)], m_we=d_we (data port only, else 0), m_be=d_be (data) or 4'hF (instruction), m_wdata=d_wdata.
REQ-010 A granted erroneous request SHALL hold m_en=0; it SHALL still be granted and SHALL receive an error response.
REQ-011 A granted request SHALL produce exactly one rvalid pulse on its own port in the next cycle (fixed latency 1); back-to-back grants SHALL give one response per cycle.
REQ-012 The response owner (port, write flag, error flag) SHALL be registered at grant; rdata SHALL come from m_rdata for a good read and SHALL be 0 for writes and errors.
REQ-013 A write response SHALL assert d_rvalid with d_err=0 and d_rdata=0; RAM write takes effect at the grant edge.
REQ-014 A non-erroneous request SHALL have err=0 in its response; i_rvalid and d_rvalid SHALL never be high in the same cycle.
REQ-015 When no request is active, m_en SHALL be 0 and the m_* data outputs SHALL be 0.

Reset
REQ-016 While rst is high at a rising edge, the following SHALL clear: starve_cnt, response-owner register, i_rvalid, d_rvalid, i_err, d_err, i_rdata, d_rdata.
REQ-017 While rst is high, i_gnt, d_gnt and m_en SHALL be 0 and requests SHALL be ignored.
REQ-018 A response pending when rst rises SHALL be discarded, with no rvalid after reset.

Verification
REQ-019 Scenario: fetch i_addr=0x04, RAM word1=0x07b08113 -> i_gnt=1, m_addr=1, m_be=F; next cycle i_rvalid=1, i_rdata=0x07b08113, i_err=0.
REQ-020 Scenario: simultaneous i_req (addr 0x00) and d_req load (addr 0x40) -> d_gnt first; d_rvalid with RAM[16]=0x3; i_gnt the following cycle.
REQ-021 Scenario: d_req held high continuously with i_req high -> i_gnt asserts on the 4th cycle (starve_cnt=3), then starve_cnt=0 and data wins again.
REQ-022 Scenario: store d_addr=0x40, d_wdata=0x3F, d_be=F, then fetch-port read of 0x40 -> d_rvalid, d_rdata=0; read returns 0x3F.
REQ-023 Scenario: d_addr=0x42 and i_addr=0x80 (MEM_WORDS=32) -> m_en=0; one-cycle error response on each port.
REQ-024 Scenario: grant in cycle N with rst high in cycle N+1 -> no rvalid in cycles N+1 or N+2; all outputs 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a shared single-port RAM.
// Requests are granted in the same cycle and answered with a fixed one-cycle latency.
module mem_arbiter #(
  parameter int unsigned MEM_WORDS  = 32,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic                         clk,
  input  logic                         rst,

  input  logic                         i_req,
  input  logic [31:0]                  i_addr,
  output logic                         i_gnt,
  output logic                         i_rvalid,
  output logic [31:0]                  i_rdata,
  output logic                         i_err,

  input  logic                         d_req,
  input  logic                         d_we,
  input  logic [3:0]                   d_be,
  input  logic [31:0]                  d_addr,
  input  logic [31:0]                  d_wdata,
  output logic                         d_gnt,
  output logic                         d_rvalid,
  output logic [31:0]                  d_rdata,
  output logic                         d_err,

  output logic                         m_en,
  output logic                         m_we,
  output logic [3:0]                   m_be,
  output logic [$clog2(MEM_WORDS)-1:0] m_addr,
  output logic [31:0]                  m_wdata,
  input  logic [31:0]                  m_rdata
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  // Registered state: starvation counter and the owner of the response in flight.
  logic [SW-1:0] starve_cnt;
  logic          rsp_valid;
  logic          rsp_data_port;
  logic          rsp_we;
  logic          rsp_err;

  logic          i_bad;
  logic          d_bad;
  logic          starved;
  logic          i_rvalid_int;
  logic          d_rvalid_int;
  logic          rsp_has_data;

  // Address legality: word aligned and inside the RAM.
  always_comb begin
    i_bad   = (i_addr[1:0] != 2'b00) || ({2'b00, i_addr[31:2]} >= 32'(MEM_WORDS));
    d_bad   = (d_addr[1:0] != 2'b00) || ({2'b00, d_addr[31:2]} >= 32'(MEM_WORDS));
    starved = (starve_cnt == SW'(STARVE_MAX));
  end

  // Arbitration and RAM drive; an illegal request is granted but never touches the RAM.
  always_comb begin
    i_gnt   = 1'b0;
    d_gnt   = 1'b0;
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_be    = 4'h0;
    m_addr  = '0;
    m_wdata = 32'h0;
    if (!rst) begin
      if (d_req && !(i_req && starved)) begin
        d_gnt = 1'b1;
      end else if (i_req) begin
        i_gnt = 1'b1;
      end

      if (d_gnt && !d_bad) begin
        m_en    = 1'b1;
        m_we    = d_we;
        m_be    = d_be;
        m_addr  = d_addr[2 +: AW];
        m_wdata = d_wdata;
      end else if (i_gnt && !i_bad) begin
        m_en    = 1'b1;
        m_we    = 1'b0;
        m_be    = 4'hF;
        m_addr  = i_addr[2 +: AW];
        m_wdata = d_wdata;
      end
    end
  end

  // Starvation counter and response-owner capture at the grant edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt    <= '0;
      rsp_valid     <= 1'b0;
      rsp_data_port <= 1'b0;
      rsp_we        <= 1'b0;
      rsp_err       <= 1'b0;
    end else begin
      if (i_req && !i_gnt) begin
        if (!starved) begin
          starve_cnt <= starve_cnt + SW'(1);
        end
      end else begin
        starve_cnt <= '0;
      end

      rsp_valid     <= i_gnt || d_gnt;
      rsp_data_port <= d_gnt;
      rsp_we        <= d_gnt && d_we;
      rsp_err       <= d_gnt ? d_bad : (i_gnt && i_bad);
    end
  end

  // Response decode; a pending response is dropped as soon as reset is asserted.
  always_comb begin
    i_rvalid_int = rsp_valid && !rsp_data_port && !rst;
    d_rvalid_int = rsp_valid &&  rsp_data_port && !rst;
    rsp_has_data = !rsp_we && !rsp_err;

    i_rvalid = i_rvalid_int;
    i_err    = i_rvalid_int && rsp_err;
    i_rdata  = (i_rvalid_int && rsp_has_data) ? m_rdata : 32'h0;

    d_rvalid = d_rvalid_int;
    d_err    = d_rvalid_int && rsp_err;
    d_rdata  = (d_rvalid_int && rsp_has_data) ? m_rdata : 32'h0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed scenarios, random traffic
// against a behavioural model of arbitration, memory contents and response timing.
module tb_mem_arbiter;

  localparam int unsigned MEM_WORDS  = 32;
  localparam int unsigned STARVE_MAX = 3;
  localparam int unsigned AW         = $clog2(MEM_WORDS);

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, i_gnt, i_rvalid, i_err;
  logic [31:0]   i_addr, i_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [3:0]    d_be;
  logic [31:0]   d_addr, d_wdata, d_rdata;
  logic          m_en, m_we;
  logic [3:0]    m_be;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata, m_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_WORDS(MEM_WORDS), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_en(m_en), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  // Single-port synchronous RAM (cleared by reset so the model starts from known data).
  logic [31:0] ram [MEM_WORDS];
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(MEM_WORDS); k++) ram[k] <= 32'h0;
      m_rdata <= 32'h0;
    end else if (m_en) begin
      if (m_we) begin
        for (int b = 0; b < 4; b++)
          if (m_be[b]) ram[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
      end else begin
        m_rdata <= ram[m_addr];
      end
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state
  int          starve = 0;
  logic [31:0] ref_mem [MEM_WORDS];
  bit          pend_v = 0, pend_d = 0, pend_err = 0;
  logic [31:0] pend_data = 32'h0;

  // Values sampled in the most recent step
  logic          s_i_gnt, s_d_gnt, s_m_en, s_i_rvalid, s_d_rvalid, s_i_err, s_d_err;
  logic [3:0]    s_m_be;
  logic [AW-1:0] s_m_addr;
  logic [31:0]   s_i_rdata, s_d_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit bad_addr(input logic [31:0] a);
    return ((a % 4) != 0) || ((a / 4) >= 32'(MEM_WORDS));
  endfunction

  // One clock cycle: drive, check every output against the model, advance the model.
  task automatic step(input bit r, input bit ir, input logic [31:0] ia,
                      input bit dr, input bit dw, input logic [3:0] db,
                      input logic [31:0] da, input logic [31:0] dwd);
    bit ie, de, gi, gd, good, exp_iv, exp_dv;
    int idx;
    logic [31:0] a;
    rst = r; i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_be = db;
    d_addr = da; d_wdata = dwd;
    @(negedge clk);
    s_i_gnt = i_gnt; s_d_gnt = d_gnt; s_m_en = m_en; s_m_be = m_be; s_m_addr = m_addr;
    s_i_rvalid = i_rvalid; s_d_rvalid = d_rvalid; s_i_err = i_err; s_d_err = d_err;
    s_i_rdata = i_rdata; s_d_rdata = d_rdata;

    ie = bad_addr(ia);
    de = bad_addr(da);
    gi = 1'b0; gd = 1'b0; idx = 0;
    if (!r) begin
      if (ir && dr) begin
        if (starve == int'(STARVE_MAX)) gi = 1'b1; else gd = 1'b1;
      end else if (ir) gi = 1'b1;
      else if (dr) gd = 1'b1;
    end
    chk("i_gnt", 32'(i_gnt), 32'(gi));
    chk("d_gnt", 32'(d_gnt), 32'(gd));
    good = (gi && !ie) || (gd && !de);
    chk("m_en", 32'(m_en), 32'(good));
    if (good) begin
      a = gd ? da : ia;
      idx = int'(a / 4);
      chk("m_addr", 32'(m_addr), 32'(idx));
      chk("m_be", 32'(m_be), gd ? 32'(db) : 32'hF);
      chk("m_we", 32'(m_we), 32'(gd && dw));
      if (gd && dw) chk("m_wdata", m_wdata, dwd);
    end else if (!gi && !gd) begin
      chk("idle_m_we", 32'(m_we), 32'h0);
      chk("idle_m_be", 32'(m_be), 32'h0);
      chk("idle_m_addr", 32'(m_addr), 32'h0);
      chk("idle_m_wdata", m_wdata, 32'h0);
    end

    exp_iv = pend_v && !pend_d && !r;
    exp_dv = pend_v &&  pend_d && !r;
    chk("i_rvalid", 32'(i_rvalid), 32'(exp_iv));
    chk("d_rvalid", 32'(d_rvalid), 32'(exp_dv));
    if (exp_iv) begin
      chk("i_err", 32'(i_err), 32'(pend_err));
      chk("i_rdata", i_rdata, pend_data);
    end
    if (exp_dv) begin
      chk("d_err", 32'(d_err), 32'(pend_err));
      chk("d_rdata", d_rdata, pend_data);
    end

    if (r) begin
      pend_v = 1'b0;
      starve = 0;
      for (int k = 0; k < int'(MEM_WORDS); k++) ref_mem[k] = 32'h0;
    end else begin
      pend_v    = gi || gd;
      pend_d    = gd;
      pend_err  = gd ? de : (gi && ie);
      pend_data = (good && !(gd && dw)) ? ref_mem[idx] : 32'h0;
      if (good && gd && dw)
        for (int b = 0; b < 4; b++)
          if (db[b]) ref_mem[idx][8*b +: 8] = dwd[8*b +: 8];
      if (ir && !gi) starve = (starve < int'(STARVE_MAX)) ? starve + 1 : starve;
      else starve = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] w);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'hF, a, w);
  endtask

  typedef struct {
    bit          ir;
    logic [31:0] ia;
    bit          dr;
    bit          dw;
    logic [3:0]  db;
    logic [31:0] da;
    logic [31:0] dwd;
    bit          e_ig;
    bit          e_dg;
    bit          e_men;
  } vec_t;

  vec_t vecs [10];
  int   gnt_seq [5];

  initial begin
    rst = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
    vecs[0] = '{1, 32'h08, 0, 0, 4'h0, 32'h00, 32'h0, 1, 0, 1};
    vecs[1] = '{0, 32'h00, 1, 0, 4'hF, 32'h10, 32'h0, 0, 1, 1};
    vecs[2] = '{0, 32'h00, 1, 1, 4'h5, 32'h7C, 32'hA5A5_1234, 0, 1, 1};
    vecs[3] = '{1, 32'h00, 1, 0, 4'hF, 32'h04, 32'h0, 0, 1, 1};
    vecs[4] = '{1, 32'h7C, 0, 0, 4'h0, 32'h00, 32'h0, 1, 0, 1};
    vecs[5] = '{1, 32'h7E, 0, 0, 4'h0, 32'h00, 32'h0, 1, 0, 0};
    vecs[6] = '{0, 32'h00, 1, 0, 4'hF, 32'h80, 32'h0, 0, 1, 0};
    vecs[7] = '{0, 32'h00, 0, 0, 4'h0, 32'h00, 32'h0, 0, 0, 0};
    vecs[8] = '{0, 32'h00, 1, 1, 4'hF, 32'hFFFF_FFFC, 32'h1, 0, 1, 0};
    vecs[9] = '{1, 32'h0C, 1, 0, 4'hF, 32'h03, 32'h0, 0, 1, 0};
    gnt_seq = '{0, 0, 0, 1, 0};

    @(posedge clk); #1;
    // Reset with requests active: nothing granted, nothing returned
    step(1'b1, 1'b1, 32'h4, 1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
    step(1'b1, 1'b1, 32'h4, 1'b1, 1'b1, 4'hF, 32'h8, 32'h1);
    chk("rst_i_gnt", 32'(s_i_gnt), 32'h0);
    chk("rst_d_gnt", 32'(s_d_gnt), 32'h0);
    chk("rst_m_en", 32'(s_m_en), 32'h0);
    idle();
    chk("post_rst_i_rvalid", 32'(s_i_rvalid), 32'h0);
    chk("post_rst_d_rvalid", 32'(s_d_rvalid), 32'h0);

    // Vector table, one request per entry with idle cycles in between
    for (int v = 0; v < 10; v++) begin
      step(1'b0, vecs[v].ir, vecs[v].ia, vecs[v].dr, vecs[v].dw, vecs[v].db,
           vecs[v].da, vecs[v].dwd);
      chk($sformatf("vec%0d_i_gnt", v), 32'(s_i_gnt), 32'(vecs[v].e_ig));
      chk($sformatf("vec%0d_d_gnt", v), 32'(s_d_gnt), 32'(vecs[v].e_dg));
      chk($sformatf("vec%0d_m_en", v), 32'(s_m_en), 32'(vecs[v].e_men));
      idle();
      idle();
    end

    // Fetch of a stored instruction word
    store(32'h4, 32'h07b0_8113);
    step(1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("fetch_i_gnt", 32'(s_i_gnt), 32'h1);
    chk("fetch_m_addr", 32'(s_m_addr), 32'h1);
    chk("fetch_m_be", 32'(s_m_be), 32'hF);
    idle();
    chk("fetch_i_rvalid", 32'(s_i_rvalid), 32'h1);
    chk("fetch_i_rdata", s_i_rdata, 32'h07b0_8113);
    chk("fetch_i_err", 32'(s_i_err), 32'h0);

    // Simultaneous requests: data first, instruction the next cycle
    store(32'h40, 32'h3);
    idle();
    step(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
    chk("both_d_gnt", 32'(s_d_gnt), 32'h1);
    chk("both_i_gnt", 32'(s_i_gnt), 32'h0);
    step(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("both_d_rvalid", 32'(s_d_rvalid), 32'h1);
    chk("both_d_rdata", s_d_rdata, 32'h3);
    chk("both_i_gnt2", 32'(s_i_gnt), 32'h1);
    idle();

    // Starvation: instruction wins on the 4th contended cycle, then data again
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 1'b1, 32'h8, 1'b1, 1'b0, 4'hF, 32'hC, 32'h0);
      chk($sformatf("starve_c%0d_i_gnt", c), 32'(s_i_gnt), 32'(gnt_seq[c]));
    end
    idle();

    // Store then fetch of the same word
    store(32'h40, 32'h3F);
    step(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("st_d_rvalid", 32'(s_d_rvalid), 32'h1);
    chk("st_d_rdata", s_d_rdata, 32'h0);
    idle();
    chk("st_fetch_rdata", s_i_rdata, 32'h3F);

    // Misaligned data and out-of-range fetch: no RAM access, error on each port
    step(1'b0, 1'b1, 32'h80, 1'b1, 1'b0, 4'hF, 32'h42, 32'h0);
    chk("err_m_en0", 32'(s_m_en), 32'h0);
    step(1'b0, 1'b1, 32'h80, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("err_m_en1", 32'(s_m_en), 32'h0);
    chk("err_d_err", 32'(s_d_err), 32'h1);
    idle();
    chk("err_i_err", 32'(s_i_err), 32'h1);
    chk("err_i_rdata", s_i_rdata, 32'h0);
    idle();
    chk("err_once", 32'({s_i_rvalid, s_d_rvalid}), 32'h0);

    // Reset right after a grant discards the response
    step(1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b1, 1'b1, 32'h4, 1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
    chk("rstp_i_rvalid", 32'(s_i_rvalid), 32'h0);
    chk("rstp_i_rdata", s_i_rdata, 32'h0);
    chk("rstp_gnt", 32'({s_i_gnt, s_d_gnt, s_m_en}), 32'h0);
    idle();
    chk("rstp_i_rvalid2", 32'(s_i_rvalid), 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      bit r, ir, dr, dw;
      logic [31:0] ia, da;
      r  = ($urandom_range(0, 49) == 0);
      ir = ($urandom_range(0, 3) != 0);
      dr = ($urandom_range(0, 3) != 0);
      dw = $urandom_range(0, 1) == 1;
      ia = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, MEM_WORDS - 1) * 4);
      da = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, MEM_WORDS - 1) * 4);
      step(r, ir, ia, dr, dw, 4'($urandom_range(0, 15)), da, $urandom);
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
